// File: rtl/alu_exec_if.sv
// alu_exec_if: operation/result bundle between the ID/EX register, the
// execute-stage ALU (alu_exec_unit) and the EX/MEM register.
//
// Handshake: an operation transfers on a rising clk edge when
// in_valid & in_ready & ~flush. Upstream must hold in_valid and all operand
// fields stable until that happens. in_ready is low while a multiply/divide
// is in flight. There is no output back-pressure: out_valid, illegal and
// md_done are single-cycle pulses that the consumer must take when they
// appear. result, zero, hi and lo hold their values between pulses.
//
// Signals (master = upstream/stage driver, slave = alu_exec_unit):
//   flush     m->s  synchronous pipeline flush
//   in_valid  m->s  operation present
//   in_ready  s->m  unit can accept (equals ~busy)
//   aluop     m->s  op class from main control
//   funct     m->s  instruction[5:0], decoded only when aluop == 000
//   shamt     m->s  constant shift amount
//   op_a      m->s  rs value
//   op_b      m->s  rt value or extended immediate
//   out_valid s->m  result valid pulse
//   result    s->m  registered result
//   zero      s->m  registered (result == 0)
//   illegal   s->m  unsupported funct pulse
//   busy      s->m  multiply/divide in progress
//   md_done   s->m  HI/LO updated pulse
//   hi, lo    s->m  architectural HI/LO registers
//   md_state  s->m  multiply/divide FSM state (debug visibility)
interface alu_exec_if #(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        aluop;
    logic [5:0]        funct;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              out_valid;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              illegal;
    logic              busy;
    logic              md_done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [1:0]        md_state;

    modport master (
        output flush, in_valid, aluop, funct, shamt, op_a, op_b,
        input  in_ready, out_valid, result, zero, illegal, busy, md_done,
               hi, lo, md_state
    );

    modport slave (
        input  flush, in_valid, aluop, funct, shamt, op_a, op_b,
        output in_ready, out_valid, result, zero, illegal, busy, md_done,
               hi, lo, md_state
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS execute-stage ALU. Decodes aluop/funct, computes
// single-cycle ALU ops with a registered result (latency 1), and runs
// iterative multiply/divide (one shift-add / restoring-subtract step per
// cycle) into the architectural HI/LO registers.
//
// Parameters:
//   DATA_W  operand/result/HI/LO width (even power of two, >= 8)
//   SH_W    shift-amount width, log2(DATA_W)
//   LUI_SH  left shift applied by aluop 111, < DATA_W
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    alu_exec_if slave modport (handshake, operands, results, HI/LO)
module alu_exec_unit #(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5,
    parameter int LUI_SH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } md_state_t;

    md_state_t state, state_nxt;

    // Multiply/divide working registers. acc holds {partial, operand} with
    // one guard bit on top for the add carry / restoring-subtract borrow.
    logic [2*DATA_W:0] acc;
    logic [DATA_W-1:0] m_b;       // multiplicand / divisor magnitude
    logic [DATA_W-1:0] raw_a;     // original op_a, needed for divide by zero
    logic [SH_W-1:0]   cnt;
    logic              fix_ph;    // FIX is two cycles: correct, then write
    logic              md_is_div;
    logic              neg_q;     // negate product / quotient
    logic              neg_r;     // negate remainder (dividend sign)
    logic              div_zero;

    logic [DATA_W-1:0] result_r, hi_r, lo_r;
    logic              zero_r, out_valid_r, illegal_r, md_done_r;

    logic              busy, accept, is_md;
    logic [DATA_W-1:0] alu_res;
    logic              bad, wr_hi, wr_lo;

    assign busy       = (state != S_IDLE);
    assign accept     = bus.in_valid && !busy && !bus.flush;
    assign is_md      = (bus.aluop == 3'b000) && (bus.funct[5:2] == 4'b0110);

    assign bus.in_ready  = !busy;
    assign bus.busy      = busy;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.out_valid = out_valid_r;
    assign bus.illegal   = illegal_r;
    assign bus.md_done   = md_done_r;
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;
    assign bus.md_state  = state;

    // ---------------- single-cycle decode ----------------
    always_comb begin
        alu_res = '0;
        bad     = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (bus.aluop)
            3'b000: begin
                case (bus.funct)
                    6'b000000: alu_res = bus.op_b << bus.shamt;
                    6'b000010: alu_res = bus.op_b >> bus.shamt;
                    6'b000011: alu_res = $signed(bus.op_b) >>> bus.shamt;
                    6'b000100: alu_res = bus.op_b << bus.op_a[SH_W-1:0];
                    6'b000110: alu_res = bus.op_b >> bus.op_a[SH_W-1:0];
                    6'b000111: alu_res = $signed(bus.op_b) >>> bus.op_a[SH_W-1:0];
                    6'b100001: alu_res = bus.op_a + bus.op_b;
                    6'b100011: alu_res = bus.op_a - bus.op_b;
                    6'b100100: alu_res = bus.op_a & bus.op_b;
                    6'b100101: alu_res = bus.op_a | bus.op_b;
                    6'b100110: alu_res = bus.op_a ^ bus.op_b;
                    6'b100111: alu_res = ~(bus.op_a | bus.op_b);
                    6'b101010: alu_res = {{(DATA_W-1){1'b0}},
                                          ($signed(bus.op_a) < $signed(bus.op_b))};
                    6'b101011: alu_res = {{(DATA_W-1){1'b0}}, (bus.op_a < bus.op_b)};
                    6'b010000: alu_res = hi_r;
                    6'b010010: alu_res = lo_r;
                    6'b010001: wr_hi = 1'b1;
                    6'b010011: wr_lo = 1'b1;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: ; // multiply/divide
                    default:   bad = 1'b1;
                endcase
            end
            3'b001:  alu_res = bus.op_a + bus.op_b;
            3'b010:  alu_res = bus.op_a & bus.op_b;
            3'b011:  alu_res = bus.op_a | bus.op_b;
            3'b100:  alu_res = bus.op_a ^ bus.op_b;
            3'b101:  alu_res = bus.op_b << bus.shamt;
            3'b110:  alu_res = bus.op_a - bus.op_b;
            default: alu_res = bus.op_b << LUI_SH;
        endcase
    end

    // ---------------- operand magnitudes at accept ----------------
    // funct[0]=0 selects the signed forms (mult, div); funct[1] selects divide.
    logic              sgn_a, sgn_b;
    logic [DATA_W-1:0] mag_a, mag_b;

    always_comb begin
        sgn_a = !bus.funct[0] && bus.op_a[DATA_W-1];
        sgn_b = !bus.funct[0] && bus.op_b[DATA_W-1];
        mag_a = sgn_a ? -bus.op_a : bus.op_a;
        mag_b = sgn_b ? -bus.op_b : bus.op_b;
    end

    // ---------------- iteration step ----------------
    logic [DATA_W:0]   add_sum, trial;
    logic [2*DATA_W:0] shl, mul_next, div_next, fix_val;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier LSB is set, then shift the whole accumulator right.
        add_sum  = acc[2*DATA_W:DATA_W] + (acc[0] ? {1'b0, m_b} : '0);
        mul_next = {1'b0, add_sum, acc[DATA_W-1:1]};
        // Divide: shift left, try subtracting the divisor from the partial
        // remainder, keep it and set the quotient bit if no borrow.
        shl      = {acc[2*DATA_W-1:0], 1'b0};
        trial    = shl[2*DATA_W:DATA_W] - {1'b0, m_b};
        div_next = trial[DATA_W] ? shl : {trial, shl[DATA_W-1:1], 1'b1};

        // Sign correction into {hi, lo} layout.
        fix_val = {1'b0, acc[2*DATA_W-1:0]};
        if (md_is_div) begin
            if (div_zero) begin
                fix_val = {1'b0, raw_a, {DATA_W{1'b1}}};
            end else begin
                fix_val = {1'b0,
                           (neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W]),
                           (neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0])};
            end
        end else if (neg_q) begin
            fix_val = {1'b0, -acc[2*DATA_W-1:0]};
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && is_md) state_nxt = S_ITER;
            S_ITER:  if (cnt == '1)       state_nxt = S_FIX;
            S_FIX:   if (fix_ph)          state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
        if (bus.flush) state_nxt = S_IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_r    <= '0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
            md_done_r   <= 1'b0;
            hi_r        <= '0;
            lo_r        <= '0;
            acc         <= '0;
            m_b         <= '0;
            raw_a       <= '0;
            cnt         <= '0;
            fix_ph      <= 1'b0;
            md_is_div   <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div_zero    <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
            md_done_r   <= 1'b0;
            if (!bus.flush) begin
                case (state)
                    S_ITER: begin
                        acc <= md_is_div ? div_next : mul_next;
                        cnt <= cnt + 1'b1;
                    end
                    S_FIX: begin
                        if (!fix_ph) begin
                            acc    <= fix_val;
                            fix_ph <= 1'b1;
                        end else begin
                            hi_r      <= acc[2*DATA_W-1:DATA_W];
                            lo_r      <= acc[DATA_W-1:0];
                            md_done_r <= 1'b1;
                            fix_ph    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
                // accept implies IDLE, so it never collides with a HI/LO write above.
                if (accept) begin
                    if (is_md) begin
                        acc       <= {{(DATA_W+1){1'b0}}, mag_a};
                        m_b       <= mag_b;
                        raw_a     <= bus.op_a;
                        cnt       <= '0;
                        fix_ph    <= 1'b0;
                        md_is_div <= bus.funct[1];
                        neg_q     <= sgn_a ^ sgn_b;
                        neg_r     <= sgn_a;
                        div_zero  <= bus.funct[1] && (bus.op_b == '0);
                    end else begin
                        result_r    <= alu_res;
                        zero_r      <= (alu_res == '0);
                        out_valid_r <= 1'b1;
                        illegal_r   <= bad;
                        if (wr_hi) hi_r <= bus.op_a;
                        if (wr_lo) lo_r <= bus.op_a;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    localparam int W = 32;

    logic clk;
    logic rst_n;

    alu_exec_if #(.DATA_W(W), .SH_W(5)) bus ();

    alu_exec_unit #(.DATA_W(W), .SH_W(5), .LUI_SH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]   aluop;
        logic [5:0]   funct;
        logic [4:0]   shamt;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_zero;
        logic         exp_ill;
        string        name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [2:0] aluop, input logic [5:0] funct, input logic [4:0] shamt,
                           input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r,
                           input logic z, input logic ill, input string name);
        vec_t v;
        v.aluop = aluop; v.funct = funct; v.shamt = shamt; v.a = a; v.b = b;
        v.exp_res = r; v.exp_zero = z; v.exp_ill = ill; v.name = name;
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] aluop, input logic [5:0] funct, input logic [4:0] shamt,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        bus.aluop    = aluop;
        bus.funct    = funct;
        bus.shamt    = shamt;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
    endtask

    task automatic issue(input logic [2:0] aluop, input logic [5:0] funct, input logic [4:0] shamt,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        drive(aluop, funct, shamt, a, b);
        step();
        bus.in_valid = 1'b0;
    endtask

    // Issue a multiply/divide and wait (bounded) for in_ready to come back.
    task automatic run_md(input logic [5:0] funct, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int cycles, output logic early_done);
        issue(3'b000, funct, 5'd0, a, b);
        cycles = 0;
        early_done = 1'b0;
        while (bus.in_ready == 1'b0 && cycles < 100) begin
            if (bus.md_done) early_done = 1'b1;
            cycles++;
            step();
        end
    endtask

    task automatic check_md(input string name, input logic [5:0] funct, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int cyc;
        logic early;
        run_md(funct, a, b, cyc, early);
        check({name, "_lat"}, W'(cyc), W'(34));
        check({name, "_done"}, W'(bus.md_done), W'(1));
        check({name, "_early"}, W'(early), W'(0));
        check({name, "_hi"}, bus.hi, exp_hi);
        check({name, "_lo"}, bus.lo, exp_lo);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        logic early;
        logic [W-1:0] hi_save, lo_save;
        logic seen;

        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.aluop    = '0;
        bus.funct    = '0;
        bus.shamt    = '0;
        bus.op_a     = '0;
        bus.op_b     = '0;

        // Table of single-cycle vectors: {aluop, funct, shamt, a, b, result, zero, illegal}.
        add_vec(3'b000, 6'b100001, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, "addu_wrap");
        add_vec(3'b000, 6'b100011, 5'd0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, "subu_zero");
        add_vec(3'b000, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, "slt_neg");
        add_vec(3'b000, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, "sltu_big");
        add_vec(3'b000, 6'b101010, 5'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "slt_min");
        add_vec(3'b000, 6'b101010, 5'd0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "slt_pos");
        add_vec(3'b000, 6'b000111, 5'd0, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0, "srav");
        add_vec(3'b111, 6'b000000, 5'd0, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0, "lui");
        add_vec(3'b000, 6'b000000, 5'd4, 32'h0000_0000, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b0, "sll");
        add_vec(3'b000, 6'b000010, 5'd4, 32'h0000_0000, 32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0, "srl");
        add_vec(3'b000, 6'b000011, 5'd4, 32'h0000_0000, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0, "sra");
        add_vec(3'b000, 6'b000100, 5'd0, 32'h0000_0024, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0, "sllv_mask");
        add_vec(3'b000, 6'b000110, 5'd0, 32'h0000_001F, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, "srlv");
        add_vec(3'b000, 6'b100100, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, "and_r");
        add_vec(3'b000, 6'b100101, 5'd0, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1'b0, 1'b0, "or_r");
        add_vec(3'b000, 6'b100110, 5'd0, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, "xor_r");
        add_vec(3'b000, 6'b100111, 5'd0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "nor_r");
        add_vec(3'b001, 6'b111111, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, "add_i");
        add_vec(3'b010, 6'b000000, 5'd0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1'b0, 1'b0, "and_i");
        add_vec(3'b011, 6'b000000, 5'd0, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1'b0, 1'b0, "or_i");
        add_vec(3'b100, 6'b000000, 5'd0, 32'h0000_FFFF, 32'h0000_0F0F, 32'h0000_F0F0, 1'b0, 1'b0, "xor_i");
        add_vec(3'b101, 6'b000000, 5'd2, 32'h0000_0000, 32'h0000_0003, 32'h0000_000C, 1'b0, 1'b0, "sll_i");
        add_vec(3'b110, 6'b000000, 5'd0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_i");
        add_vec(3'b000, 6'b111111, 5'd0, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1'b1, "illegal");

        // Reset
        step();
        step();
        check("rst_result", bus.result, 32'h0);
        check("rst_zero", W'(bus.zero), W'(0));
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_md_done", W'(bus.md_done), W'(0));
        rst_n = 1'b1;
        step();

        // Table-driven single-cycle ops
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp_res);
            issue(vecs[i].aluop, vecs[i].funct, vecs[i].shamt, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_valid"}, W'(bus.out_valid), W'(1));
            check({vecs[i].name, "_result"}, bus.result, exp_q.pop_front());
            check({vecs[i].name, "_zero"}, W'(bus.zero), W'(vecs[i].exp_zero));
            check({vecs[i].name, "_illegal"}, W'(bus.illegal), W'(vecs[i].exp_ill));
        end
        step();
        check("pulse_valid_low", W'(bus.out_valid), W'(0));
        check("pulse_illegal_low", W'(bus.illegal), W'(0));
        check("result_hold", bus.result, 32'h0);

        // mthi / mtlo, then illegal leaves them alone
        issue(3'b000, 6'b010001, 5'd0, 32'h1111_1111, 32'h0);
        check("mthi_valid", W'(bus.out_valid), W'(1));
        check("mthi_result", bus.result, 32'h0);
        check("mthi_hi", bus.hi, 32'h1111_1111);
        issue(3'b000, 6'b010011, 5'd0, 32'h2222_2222, 32'h0);
        check("mtlo_lo", bus.lo, 32'h2222_2222);
        issue(3'b000, 6'b111111, 5'd0, 32'hDEAD_BEEF, 32'h0);
        check("ill_hi_keep", bus.hi, 32'h1111_1111);
        check("ill_lo_keep", bus.lo, 32'h2222_2222);

        // mult -3 * 7: no out_valid on accept, 34 busy cycles
        issue(3'b000, 6'b011000, 5'd0, 32'hFFFF_FFFD, 32'h0000_0007);
        check("mult_no_valid", W'(bus.out_valid), W'(0));
        check("mult_busy", W'(bus.busy), W'(1));
        cyc = 1;
        early = 1'b0;
        while (bus.in_ready == 1'b0 && cyc < 100) begin
            if (bus.md_done) early = 1'b1;
            step();
            if (bus.in_ready == 1'b0) cyc++;
        end
        check("mult_ready_low_cycles", W'(cyc), W'(34));
        check("mult_early", W'(early), W'(0));
        check("mult_done", W'(bus.md_done), W'(1));
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFEB);
        issue(3'b000, 6'b010000, 5'd0, 32'h0, 32'h0);
        check("mfhi_result", bus.result, 32'hFFFF_FFFF);

        // More multiply/divide cases
        check_md("multu_max", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        check_md("div_neg", 6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check_md("div_negb", 6'b011010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        check_md("divu_zero", 6'b011011, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        check_md("div_zero", 6'b011010, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // mflo held during a divu: taken only after md_done
        issue(3'b000, 6'b011011, 5'd0, 32'd100, 32'd7);
        drive(3'b000, 6'b010010, 5'd0, 32'h0, 32'h0);
        cyc = 0;
        seen = 1'b0;
        while (bus.out_valid == 1'b0 && cyc < 100) begin
            step();
            cyc++;
            if (bus.md_done) seen = 1'b1;
        end
        bus.in_valid = 1'b0;
        check("mflo_wait_cycles", W'(cyc), W'(35));
        check("mflo_saw_done", W'(seen), W'(1));
        check("mflo_result", bus.result, 32'd14);
        check("divu_hi", bus.hi, 32'd2);

        // flush a divu at cycle 10
        hi_save = bus.hi;
        lo_save = bus.lo;
        issue(3'b000, 6'b011011, 5'd0, 32'h1234_5678, 32'd3);
        repeat (9) step();
        check("flush_pre_busy", W'(bus.busy), W'(1));
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_busy", W'(bus.busy), W'(0));
        check("flush_in_ready", W'(bus.in_ready), W'(1));
        seen = 1'b0;
        repeat (40) begin
            step();
            if (bus.md_done) seen = 1'b1;
        end
        check("flush_no_done", W'(seen), W'(0));
        check("flush_hi", bus.hi, hi_save);
        check("flush_lo", bus.lo, lo_save);

        // flush and in_valid together: nothing accepted
        drive(3'b001, 6'b000000, 5'd0, 32'h0000_0010, 32'h0000_0020);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_acc_valid", W'(bus.out_valid), W'(0));
        check("flush_acc_result", bus.result, 32'd14);

        // reset in the middle of a mult
        issue(3'b000, 6'b011001, 5'd0, 32'h0000_1000, 32'h0000_1000);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        check("rstmid_busy", W'(bus.busy), W'(0));
        check("rstmid_hi", bus.hi, 32'h0);
        check("rstmid_lo", bus.lo, 32'h0);
        check("rstmid_result", bus.result, 32'h0);
        check("rstmid_zero", W'(bus.zero), W'(0));
        check("rstmid_out_valid", W'(bus.out_valid), W'(0));
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            step();
            if (bus.md_done || bus.busy) seen = 1'b1;
        end
        check("rstmid_quiet", W'(seen), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execute-stage ALU for the MIPS pipeline. It merges ALU-control decode (aluop + funct) with a registered datapath.
- Adds iterative multi-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO registers, MFHI/MFLO/MTHI/MTLO, SLTU, and a correct signed SLT.
- Sits between ID/EX and EX/MEM. It stalls the front end via in_ready while a multiply/divide is in flight.

Parameters:
- DATA_W, 32, operand/result/HI/LO width; must be even and a power of two, at least 8.
- SH_W, 5, shift-amount width; must equal log2(DATA_W).
- LUI_SH, 16, left shift applied by aluop 111; must be less than DATA_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  operation present.
- in_ready  out  1  unit can accept; equals ~busy.
- aluop  in  3  op class from main control.
- funct  in  6  instruction[5:0]; used only when aluop=000.
- shamt  in  SH_W  constant shift amount.
- op_a  in  DATA_W  rs value.
- op_b  in  DATA_W  rt value or extended immediate.
- out_valid  out  1  one-cycle pulse: result valid.
- result  out  DATA_W  registered result.
- zero  out  1  registered (result == 0).
- illegal  out  1  one-cycle pulse: unsupported funct.
- busy  out  1  multiply/divide in progress.
- md_done  out  1  one-cycle pulse: HI/LO updated.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.

Behaviour:
- Reset (rst_n=0 at clk edge): result=0, zero=0 (forced), out_valid=0, illegal=0, md_done=0, busy=0, hi=0, lo=0; any multiply/divide is aborted.
- Accept: an operation is taken on a clk edge when in_valid & in_ready & ~flush.
- Single-cycle ops:
  - result/zero update on the accepting edge; out_valid=1 for exactly that following cycle. Latency 1. No output back-pressure.
- aluop decode:
  - 001 add; 010 and; 011 or; 100 xor; 101 op_b<<shamt; 110 op_a-op_b; 111 op_b<<LUI_SH.
  - All arithmetic is modulo 2^DATA_W; no overflow trap.
- aluop=000, funct decode:
  - Shifts: 000000 sll, 000010 srl, 000011 sra use shamt as the amount. 000100 sllv, 000110 srlv, 000111 srav use op_a[SH_W-1:0] as the amount. All shifts operate on op_b.
  - Arithmetic/logic: 100001 addu, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt (signed) and 101011 sltu (unsigned) return 1 or 0.
  - HI/LO access: 010000 mfhi returns hi; 010010 mflo returns lo; 010001 mthi sets hi=op_a; 010011 mtlo sets lo=op_a. mthi/mtlo are accepted, update the register on the accepting edge, and produce out_valid=1, result=0.
  - Any other funct: result=0, out_valid=1, illegal=1 for one cycle; hi/lo untouched.
- Multiply/divide: 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - Accepting edge: latch operands (magnitudes plus sign flags for the signed forms); busy=1, so in_ready=0. No out_valid is produced.
  - FSM: IDLE -> ITER (DATA_W cycles, one shift-add or restoring-subtract step per cycle) -> FIX (sign correction, HI/LO write) -> IDLE.
  - md_done=1 and new hi/lo are visible exactly DATA_W+2 cycles after the accepting edge. busy falls in the same cycle, so a new op can be accepted on the next edge.
  - Multiply result: {hi,lo} = 2*DATA_W-bit product.
  - Divide result: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - Divide by zero (div or divu): hi=op_a, lo=all ones. The sequence and latency are identical to a normal divide.
- While busy:
  - mfhi/mflo cannot be accepted (in_ready=0). Upstream holds in_valid; the op is taken after md_done.
- flush:
  - out_valid=0 and illegal=0 next cycle.
  - Aborts ITER/FIX: busy=0 next cycle, hi/lo keep their pre-op values, md_done not asserted.
  - flush and in_valid in the same cycle: flush wins, nothing accepted.
- Priority when several events coincide in one cycle: rst_n, then flush, then FSM, then accept.
- result holds its last value when out_valid=0.

Test Plan:
- Reset then addu op_a=0x7FFFFFFF, op_b=1 -> next cycle out_valid=1, result=0x80000000, zero=0. Then subu 5,5 -> result=0, zero=1.
- slt op_a=0xFFFFFFFF, op_b=1 -> result=1. sltu on the same operands -> result=0. srav op_a=4, op_b=0x80000000 -> result=0xF8000000. aluop=111, op_b=0x1234 -> result=0x12340000.
- mult op_a=0xFFFFFFFD (-3), op_b=7 -> in_ready=0 for 34 cycles; md_done at cycle 34 with hi=0xFFFFFFFF, lo=0xFFFFFFEB. A subsequent mfhi returns 0xFFFFFFFF.
- div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> hi=7, lo=0xFFFFFFFF. mflo held in_valid during busy is accepted only after md_done.
- divu in flight, then flush at cycle 10 -> busy=0 next cycle, no md_done, hi/lo unchanged. rst_n low mid-mult -> all outputs 0 next edge.
- funct=111111, aluop=000 -> out_valid=1, illegal=1, result=0 for one cycle; hi/lo unchanged.
